// File: rtl/coord_cmd_sequencer_if.sv
// Parameter-set request channel into the coordinate command sequencer:
// valid/ready handshake plus the field-write payload.
interface coord_cmd_sequencer_if;
  logic        req_valid;
  logic        req_ready;
  logic [5:0]  req_mask;
  logic        req_sync;
  logic [12:0] req_x_left;
  logic [12:0] req_y_top;
  logic [9:0]  req_x_inc_col;
  logic [9:0]  req_y_inc_col;
  logic [7:0]  req_x_inc_row;
  logic [7:0]  req_y_inc_row;

  modport master (
    output req_valid, req_mask, req_sync, req_x_left, req_y_top,
           req_x_inc_col, req_y_inc_col, req_x_inc_row, req_y_inc_row,
    input  req_ready
  );

  modport slave (
    input  req_valid, req_mask, req_sync, req_x_left, req_y_top,
           req_x_inc_col, req_y_inc_col, req_x_inc_row, req_y_inc_row,
    output req_ready
  );
endinterface

// File: rtl/coord_cmd_sequencer.sv
// Turns a masked parameter-set request into a stream of SET_* commands
// for the coordinate controller, optionally aligned to a frame start.
//   state      | meaning
//   IDLE       | accepting requests, DEMO/NONE per demo_en
//   WAIT_FRAME | request captured, holding until next_frame
//   ISSUE      | one SET_* per cycle for each set mask bit
//   DONE       | one-cycle completion pulse
module coord_cmd_sequencer #(
  parameter int BITS = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  coord_cmd_sequencer_if.slave  req,
  input  logic                  demo_en,
  input  logic                  next_frame,
  output logic [2:0]            ctrl,
  output logic [12:0]           value,
  output logic                  busy,
  output logic                  done
);
  if (BITS < 13) begin : g_bits_chk
    $error("coord_cmd_sequencer: BITS must be at least 13");
  end

  localparam logic [2:0] CMD_DEMO      = 3'b000;
  localparam logic [2:0] CMD_SET_LEFT  = 3'b001;
  localparam logic [2:0] CMD_SET_TOP   = 3'b010;
  localparam logic [2:0] CMD_NONE      = 3'b011;
  localparam logic [2:0] CMD_INC_COL_X = 3'b100;
  localparam logic [2:0] CMD_INC_COL_Y = 3'b101;
  localparam logic [2:0] CMD_INC_ROW_X = 3'b110;
  localparam logic [2:0] CMD_INC_ROW_Y = 3'b111;

  typedef enum logic [1:0] {S_IDLE, S_WAIT_FRAME, S_ISSUE, S_DONE} state_e;

  state_e      state_q, state_d;
  logic [2:0]  idx_q, idx_d;
  logic [2:0]  ctrl_q, ctrl_d;
  logic [12:0] value_q, value_d;

  logic [5:0]  mask_q;
  logic [12:0] left_q, top_q;
  logic [9:0]  xcol_q, ycol_q;
  logic [7:0]  xrow_q, yrow_q;

  logic        hs;
  logic [5:0]  mask_src;
  logic [12:0] left_src, top_src;
  logic [9:0]  xcol_src, ycol_src;
  logic [7:0]  xrow_src, yrow_src;
  logic [2:0]  start;
  logic        found;
  logic [2:0]  sel;
  logic [2:0]  cmd_code;
  logic [12:0] cmd_val;

  assign hs          = req.req_valid && (state_q == S_IDLE);
  assign req.req_ready = (state_q == S_IDLE);
  assign ctrl        = ctrl_q;
  assign value       = value_q;
  assign busy        = (state_q == S_WAIT_FRAME) || (state_q == S_ISSUE);
  assign done        = (state_q == S_DONE);

  // The first command goes out on the handshake edge itself, so it is
  // picked from the live request rather than the not-yet-loaded shadows.
  always_comb begin
    mask_src = hs ? req.req_mask      : mask_q;
    left_src = hs ? req.req_x_left    : left_q;
    top_src  = hs ? req.req_y_top     : top_q;
    xcol_src = hs ? req.req_x_inc_col : xcol_q;
    ycol_src = hs ? req.req_y_inc_col : ycol_q;
    xrow_src = hs ? req.req_x_inc_row : xrow_q;
    yrow_src = hs ? req.req_y_inc_row : yrow_q;
    start    = hs ? 3'd0 : idx_q;
    found    = 1'b0;
    sel      = 3'd0;
    for (int i = 0; i < 6; i++) begin
      if (!found && (i >= int'(start)) && mask_src[3'(i)]) begin
        found = 1'b1;
        sel   = 3'(i);
      end
    end
  end

  always_comb begin
    cmd_code = CMD_NONE;
    cmd_val  = '0;
    case (sel)
      3'd0: begin cmd_code = CMD_SET_LEFT;  cmd_val = left_src;           end
      3'd1: begin cmd_code = CMD_SET_TOP;   cmd_val = top_src;            end
      3'd2: begin cmd_code = CMD_INC_COL_X; cmd_val = {3'b000, xcol_src}; end
      3'd3: begin cmd_code = CMD_INC_COL_Y; cmd_val = {3'b000, ycol_src}; end
      3'd4: begin cmd_code = CMD_INC_ROW_X; cmd_val = {5'b0, xrow_src};   end
      3'd5: begin cmd_code = CMD_INC_ROW_Y; cmd_val = {5'b0, yrow_src};   end
      default: ;
    endcase
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    ctrl_d  = CMD_NONE;
    value_d = '0;
    unique case (state_q)
      S_IDLE: begin
        if (demo_en) ctrl_d = CMD_DEMO;
        if (hs) begin
          ctrl_d = CMD_NONE;
          idx_d  = '0;
          if (req.req_sync) begin
            state_d = S_WAIT_FRAME;
          end else begin
            state_d = S_ISSUE;
            if (found) begin
              ctrl_d  = cmd_code;
              value_d = cmd_val;
              idx_d   = sel + 3'd1;
            end
          end
        end
      end
      S_WAIT_FRAME: begin
        if (next_frame) begin
          if (found) begin
            state_d = S_ISSUE;
            ctrl_d  = cmd_code;
            value_d = cmd_val;
            idx_d   = sel + 3'd1;
          end else begin
            state_d = S_DONE;
          end
        end
      end
      S_ISSUE: begin
        // A frame strobe steals this slot; the index holds so nothing is lost.
        if (!next_frame) begin
          if (found) begin
            ctrl_d  = cmd_code;
            value_d = cmd_val;
            idx_d   = sel + 3'd1;
          end else begin
            state_d = S_DONE;
          end
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
        idx_d   = '0;
        if (demo_en) ctrl_d = CMD_DEMO;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      ctrl_q  <= CMD_NONE;
      value_q <= '0;
      mask_q  <= '0;
      left_q  <= '0;
      top_q   <= '0;
      xcol_q  <= '0;
      ycol_q  <= '0;
      xrow_q  <= '0;
      yrow_q  <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      ctrl_q  <= ctrl_d;
      value_q <= value_d;
      if (hs) begin
        mask_q <= req.req_mask;
        left_q <= req.req_x_left;
        top_q  <= req.req_y_top;
        xcol_q <= req.req_x_inc_col;
        ycol_q <= req.req_y_inc_col;
        xrow_q <= req.req_x_inc_row;
        yrow_q <= req.req_y_inc_row;
      end
    end
  end
endmodule

// File: tb/tb_coord_cmd_sequencer.sv
// Directed, table-driven bench for coord_cmd_sequencer: request vectors with
// hand-computed command streams, plus sync, reset-abort and demo sequences.
module tb_coord_cmd_sequencer;
  logic        clk = 1'b0;
  logic        rst;
  logic        demo_en;
  logic        next_frame;
  logic [2:0]  ctrl;
  logic [12:0] value;
  logic        busy;
  logic        done;

  coord_cmd_sequencer_if bus();

  coord_cmd_sequencer #(.BITS(16)) dut (
    .clk        (clk),
    .rst        (rst),
    .req        (bus),
    .demo_en    (demo_en),
    .next_frame (next_frame),
    .ctrl       (ctrl),
    .value      (value),
    .busy       (busy),
    .done       (done)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  typedef struct packed {
    logic             demo;
    logic [5:0]       mask;
    logic [12:0]      left;
    logic [12:0]      top;
    logic [9:0]       icx;
    logic [9:0]       icy;
    logic [7:0]       irx;
    logic [7:0]       iry;
    int               nf;     // observed cycle in which next_frame is raised, -1 none
    int               ncyc;   // busy cycles before the done pulse
    logic [7:0][2:0]  ectrl;
    logic [7:0][12:0] evalue;
  } vec_t;

  localparam int NVEC = 6;
  vec_t vecs[NVEC];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_exp(input int v, input int k, input logic [2:0] c, input logic [12:0] val);
    vecs[v].ectrl[k]  = c;
    vecs[v].evalue[k] = val;
  endtask

  task automatic set_fields(input int v, input logic [5:0] m, input logic [12:0] l,
                            input logic [12:0] t, input logic [9:0] cx, input logic [9:0] cy,
                            input logic [7:0] rx, input logic [7:0] ry);
    vecs[v].mask = m; vecs[v].left = l; vecs[v].top = t;
    vecs[v].icx = cx; vecs[v].icy = cy; vecs[v].irx = rx; vecs[v].iry = ry;
  endtask

  task automatic fill_table();
    for (int v = 0; v < NVEC; v++) begin
      vecs[v] = '0;
      vecs[v].nf = -1;
    end
    // full write
    set_fields(0, 6'b111111, 13'h1F00, 13'h0600, 10'h0F0, 10'h000, 8'h00, 8'hCD);
    vecs[0].ncyc = 6;
    set_exp(0, 0, 3'b001, 13'h1F00); set_exp(0, 1, 3'b010, 13'h0600);
    set_exp(0, 2, 3'b100, 13'h00F0); set_exp(0, 3, 3'b101, 13'h0000);
    set_exp(0, 4, 3'b110, 13'h0000); set_exp(0, 5, 3'b111, 13'h00CD);
    // sparse mask 000101
    set_fields(1, 6'b000101, 13'h0123, 13'h0AAA, 10'h3FF, 10'h155, 8'h11, 8'h22);
    vecs[1].ncyc = 2;
    set_exp(1, 0, 3'b001, 13'h0123); set_exp(1, 1, 3'b100, 13'h03FF);
    // empty mask: one ISSUE cycle showing NONE, then done
    set_fields(2, 6'b000000, 13'h1234, 13'h0567, 10'h2AA, 10'h111, 8'h33, 8'h44);
    vecs[2].ncyc = 1;
    set_exp(2, 0, 3'b011, 13'h0000);
    // frame collision on the edge that would issue the third command
    set_fields(3, 6'b111111, 13'h1F00, 13'h0600, 10'h0F0, 10'h000, 8'h00, 8'hCD);
    vecs[3].nf = 1; vecs[3].ncyc = 7;
    set_exp(3, 0, 3'b001, 13'h1F00); set_exp(3, 1, 3'b010, 13'h0600);
    set_exp(3, 2, 3'b011, 13'h0000); set_exp(3, 3, 3'b100, 13'h00F0);
    set_exp(3, 4, 3'b101, 13'h0000); set_exp(3, 5, 3'b110, 13'h0000);
    set_exp(3, 6, 3'b111, 13'h00CD);
    // row increments with demo active, zero-extension of 8-bit fields
    set_fields(4, 6'b110000, 13'h1111, 13'h0222, 10'h333, 10'h0AA, 8'hFF, 8'h80);
    vecs[4].demo = 1'b1; vecs[4].ncyc = 2;
    set_exp(4, 0, 3'b110, 13'h00FF); set_exp(4, 1, 3'b111, 13'h0080);
    // top and inc_col_y, zero-extension of 10-bit field
    set_fields(5, 6'b001010, 13'h0777, 13'h1FFF, 10'h001, 10'h2AA, 8'h55, 8'h66);
    vecs[5].ncyc = 2;
    set_exp(5, 0, 3'b010, 13'h1FFF); set_exp(5, 1, 3'b101, 13'h02AA);
  endtask

  task automatic drive_req(input int v, input logic sync);
    bus.req_valid     = 1'b1;
    bus.req_sync      = sync;
    bus.req_mask      = vecs[v].mask;
    bus.req_x_left    = vecs[v].left;
    bus.req_y_top     = vecs[v].top;
    bus.req_x_inc_col = vecs[v].icx;
    bus.req_y_inc_col = vecs[v].icy;
    bus.req_x_inc_row = vecs[v].irx;
    bus.req_y_inc_row = vecs[v].iry;
  endtask

  // After the handshake the request lines carry junk; the DUT must ignore it.
  task automatic scramble(input int v);
    bus.req_sync      = 1'b1;
    bus.req_mask      = ~vecs[v].mask;
    bus.req_x_left    = 13'($urandom);
    bus.req_y_top     = 13'($urandom);
    bus.req_x_inc_col = 10'($urandom);
    bus.req_y_inc_col = 10'($urandom);
    bus.req_x_inc_row = 8'($urandom);
    bus.req_y_inc_row = 8'($urandom);
  endtask

  task automatic run_vec(input int v, input logic sync, input int wait_n);
    demo_en = vecs[v].demo;
    if (vecs[v].demo) begin
      tick();
      tick();
      chk($sformatf("v%0d_demo_idle_ctrl", v), 32'(ctrl), 32'(3'b000));
      chk($sformatf("v%0d_demo_idle_value", v), 32'(value), 32'd0);
    end
    chk($sformatf("v%0d_ready_idle", v), 32'(bus.req_ready), 32'd1);
    drive_req(v, sync);
    tick();
    scramble(v);
    if (sync) begin
      for (int k = 0; k < wait_n; k++) begin
        chk($sformatf("v%0d_wait%0d_ctrl", v, k), 32'(ctrl), 32'(3'b011));
        chk($sformatf("v%0d_wait%0d_busy", v, k), 32'(busy), 32'd1);
        if (k == 0) chk($sformatf("v%0d_wait_ready", v), 32'(bus.req_ready), 32'd0);
        next_frame = (k == wait_n - 1);
        tick();
      end
      next_frame = 1'b0;
    end
    for (int k = 0; k < vecs[v].ncyc; k++) begin
      chk($sformatf("v%0d_c%0d_ctrl", v, k), 32'(ctrl), 32'(vecs[v].ectrl[k]));
      chk($sformatf("v%0d_c%0d_value", v, k), 32'(value), 32'(vecs[v].evalue[k]));
      chk($sformatf("v%0d_c%0d_busy", v, k), 32'(busy), 32'd1);
      chk($sformatf("v%0d_c%0d_done", v, k), 32'(done), 32'd0);
      next_frame = (k == vecs[v].nf);
      tick();
    end
    next_frame    = 1'b0;
    bus.req_valid = 1'b0;
    chk($sformatf("v%0d_done_pulse", v), 32'(done), 32'd1);
    chk($sformatf("v%0d_done_ctrl", v), 32'(ctrl), 32'(3'b011));
    chk($sformatf("v%0d_done_value", v), 32'(value), 32'd0);
    chk($sformatf("v%0d_done_busy", v), 32'(busy), 32'd0);
    tick();
    chk($sformatf("v%0d_after_done", v), 32'(done), 32'd0);
    chk($sformatf("v%0d_after_ready", v), 32'(bus.req_ready), 32'd1);
    chk($sformatf("v%0d_after_ctrl", v), 32'(ctrl), vecs[v].demo ? 32'(3'b000) : 32'(3'b011));
    demo_en = 1'b0;
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; demo_en = 1'b0; next_frame = 1'b0;
    bus.req_valid = 1'b0; bus.req_sync = 1'b0; bus.req_mask = '0;
    bus.req_x_left = '0; bus.req_y_top = '0; bus.req_x_inc_col = '0;
    bus.req_y_inc_col = '0; bus.req_x_inc_row = '0; bus.req_y_inc_row = '0;
    tick();
    tick();
    chk("reset_ctrl", 32'(ctrl), 32'(3'b011));
    chk("reset_value", 32'(value), 32'd0);
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_done", 32'(done), 32'd0);
    rst = 1'b0;
    tick();
    chk("post_reset_ready", 32'(bus.req_ready), 32'd1);
    chk("post_reset_ctrl", 32'(ctrl), 32'(3'b011));

    fill_table();
    for (int v = 0; v < NVEC; v++) run_vec(v, 1'b0, 0);

    // frame-synchronised full write, strobe 20 cycles after the handshake
    run_vec(0, 1'b1, 20);

    // reset in the middle of a full write
    drive_req(0, 1'b0);
    tick();
    bus.req_valid = 1'b0;
    chk("abort_c0_ctrl", 32'(ctrl), 32'(3'b001));
    tick();
    chk("abort_c1_ctrl", 32'(ctrl), 32'(3'b010));
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    chk("abort_rel_ctrl", 32'(ctrl), 32'(3'b011));
    chk("abort_rel_value", 32'(value), 32'd0);
    chk("abort_rel_busy", 32'(busy), 32'd0);
    chk("abort_rel_done", 32'(done), 32'd0);
    chk("abort_rel_ready", 32'(bus.req_ready), 32'd1);
    for (int k = 0; k < 4; k++) begin
      tick();
      chk($sformatf("abort_idle%0d_ctrl", k), 32'(ctrl), 32'(3'b011));
      chk($sformatf("abort_idle%0d_done", k), 32'(done), 32'd0);
      chk($sformatf("abort_idle%0d_busy", k), 32'(busy), 32'd0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/coord_cmd_sequencer.md
COORD_CMD_SEQUENCER -- requirements
Module: coord_cmd_sequencer

Interface
REQ-001 SHALL have parameter BITS, default 16, meaning the coordinate word width of the downstream coordinate controller; the command value width is fixed at 13 bits.
REQ-002 SHALL have ports (clock and reset first):
- clk  in  1  sole clock; all logic on rising edge.
- rst  in  1  reset, synchronous, active-high.
- req_valid  in  1  parameter-set request valid.
- req_ready  out  1  sequencer can accept a request.
- req_mask  in  6  field write enables: bit0 left, bit1 top, bit2 inc_col_x, bit3 inc_col_y, bit4 inc_row_x, bit5 inc_row_y.
- req_sync  in  1  1 = hold all writes until the next next_frame pulse.
- req_x_left  in  13  left-edge value.
- req_y_top  in  13  top-edge value.
- req_x_inc_col  in  10  per-pixel x increment.
- req_y_inc_col  in  10  per-pixel y increment.
- req_x_inc_row  in  8  per-row x increment.
- req_y_inc_row  in  8  per-row y increment.
- demo_en  in  1  emit the demo command when idle.
- next_frame  in  1  frame-start strobe from the display timing.
- ctrl  out  3  command code to the coordinate controller.
- value  out  13  command operand.
- busy  out  1  a request is in progress.
- done  out  1  one-cycle pulse at request completion.

Function
REQ-003 SHALL use these command codes: DEMO 000, SET_LEFT 001, SET_TOP 010, NONE 011, SET_INC_COL_X 100, SET_INC_COL_Y 101, SET_INC_ROW_X 110, SET_INC_ROW_Y 111.
REQ-004 SHALL drive ctrl and value from registers; no combinational path from any input to ctrl or value.
REQ-005 SHALL implement the states IDLE, WAIT_FRAME, ISSUE, and DONE.
REQ-006 SHALL assert req_ready only in IDLE; a handshake is req_valid and req_ready both high at a rising edge.
REQ-007 On handshake, SHALL capture all req_* inputs into internal shadow registers; later changes on req_* SHALL have no effect until the next handshake.
REQ-008 On handshake, SHALL enter WAIT_FRAME if req_sync=1, otherwise ISSUE.
REQ-009 SHALL leave WAIT_FRAME for ISSUE at the edge where next_frame=1; ctrl SHALL be NONE while in WAIT_FRAME.
REQ-010 In ISSUE, SHALL emit one command per cycle for each set mask bit, in the fixed order bit0 to bit5, skipping clear bits with no idle cycle between emitted commands.
REQ-011 SHALL zero-extend 10-bit and 8-bit fields into value[12:0].
REQ-012 SHALL, on any edge in ISSUE where next_frame=1, load ctrl=NONE and value=0, hold the command index, and resume the sequence on the following edge; no command is lost or duplicated.
REQ-013 After the final command cycle, SHALL enter DONE for exactly one cycle with done=1 and ctrl=NONE, then return to IDLE.
REQ-014 With req_mask=0, SHALL go from ISSUE (or WAIT_FRAME) directly to DONE and emit no SET_* command.
REQ-015 SHALL assert busy in WAIT_FRAME and ISSUE; busy=0 in IDLE and DONE.
REQ-016 In IDLE, SHALL drive ctrl=DEMO, value=0 when demo_en=1, and ctrl=NONE, value=0 when demo_en=0.
REQ-017 SHALL ignore demo_en outside IDLE, so that DEMO never interleaves with a SET_* sequence.
REQ-018 SHALL make the first command visible in the cycle after the handshake (latency 1) when req_sync=0.
REQ-019 When req_sync=1, SHALL make the first command visible in the cycle after the next_frame edge.

Reset
REQ-020 While rst=1 at an edge, SHALL force state IDLE, ctrl=NONE (011), value=0, busy=0, done=0, and clear all shadow registers and the command index.
REQ-021 SHALL abort any in-progress sequence on reset without emitting further SET_* commands and without a done pulse.
REQ-022 SHALL drive req_ready=1 from the first cycle after rst deasserts, and SHALL apply DEMO output per demo_en from that cycle.

Verification
REQ-023 Reset: rst=1 for 2 cycles mid-sequence with demo_en=0, then released -> ctrl=011, value=0, busy=0, done=0, no pending commands, req_ready=1.
REQ-024 Full write: mask=111111, sync=0, left=0x1F00, top=0x0600, inc_col_x=0x0F0, inc_col_y=0, inc_row_x=0, inc_row_y=0xCD -> over 6 consecutive cycles, ctrl/value = 001/0x1F00, 010/0x0600, 100/0x00F0, 101/0, 110/0, 111/0x00CD; then done=1 for one cycle with ctrl=011.
REQ-025 Sparse mask: mask=000101 -> ctrl 001 then 100 on consecutive cycles, then done on the following cycle; mask=000000 -> done one cycle after ISSUE entry, no SET_* commands.
REQ-026 Frame collision: next_frame=1 on the edge that would issue the third command of a full write -> that cycle shows 011, the third through sixth commands follow in order, 7 cycles total.
REQ-027 Sync: sync=1, next_frame pulsed 20 cycles after the handshake -> ctrl=011 and busy=1 for those cycles, first SET_LEFT in the cycle after the pulse.
REQ-028 Demo: demo_en=1 while idle -> ctrl=000; a request during demo -> SET_* sequence with no 000 cycles between commands, and 000 resumes the cycle after done.
